// File: rtl/dpd_pkg.sv
// -----------------------------------------------------------------------------
// dpd_pkg
// Shared definitions for the memoryless DPD polynomial gain block:
//   - sample / coefficient / magnitude widths
//   - coefficient bank address map (real parts at 0..4, imaginary at 8..12)
//   - COEF_UNITY, the Q2.18 encoding of 1.0
//   - round_sat(): round half-up at a given bit, arithmetic shift, then
//     saturate to a signed 20-bit result, reporting whether it clipped
// No ports (package).
// -----------------------------------------------------------------------------
package dpd_pkg;

    localparam int SAMPLE_W  = 20;
    localparam int COEF_W    = 20;
    localparam int MAG_W     = 20;
    localparam int NUM_TERMS = 5;

    // Wide enough for every intermediate sum plus its rounding constant.
    localparam int ACC_W = 48;

    localparam logic [3:0] ADDR_RE_BASE = 4'd0;
    localparam logic [3:0] ADDR_IM_BASE = 4'd8;

    localparam logic signed [COEF_W-1:0] COEF_UNITY = 20'sd262144;

    // Rounding points: Q1.19 * Q2.18 -> Q2.18 drops 19 bits,
    // Q1.19 * Q2.18 -> Q1.19 drops 18 bits.
    localparam int unsigned G_SHIFT = 19;
    localparam int unsigned Y_SHIFT = 18;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic signed [COEF_W-1:0]   coef_t;

    typedef struct packed {
        logic    sat;
        sample_t val;
    } rs_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 48'sd524287;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -48'sd524288;

    function automatic rs_t round_sat(input logic signed [ACC_W-1:0] v,
                                      input int unsigned             shift);
        logic signed [ACC_W-1:0] half;
        logic signed [ACC_W-1:0] r;
        rs_t                     res;
        half = {{(ACC_W-1){1'b0}}, 1'b1} << (shift - 1);
        r    = (v + half) >>> shift;
        if (r > SAT_MAX) begin
            res.sat = 1'b1;
            res.val = SAT_MAX[SAMPLE_W-1:0];
        end else if (r < SAT_MIN) begin
            res.sat = 1'b1;
            res.val = SAT_MIN[SAMPLE_W-1:0];
        end else begin
            res.sat = 1'b0;
            res.val = r[SAMPLE_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/dpd_coef_bank.sv
// -----------------------------------------------------------------------------
// dpd_coef_bank
// Double-buffered complex coefficient store for the DPD polynomial.
// Software writes land in a shadow bank; a commit pulse copies the whole
// shadow bank into the active bank in one cycle, so the datapath never sees
// a half-updated coefficient set. A write coinciding with a commit goes to
// the shadow bank only; the commit copies the pre-write shadow contents.
// Both banks reset to identity (Re c_0 = 1.0, all others 0).
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   coef_wr_en_i    shadow write strobe
//   coef_addr_i     0..4 = Re c_0..c_4, 8..12 = Im c_0..c_4, others ignored
//   coef_wdata_i    Q2.18 coefficient value
//   coef_commit_i   copy shadow -> active
//   coef_re_o[k]    active Re c_k
//   coef_im_o[k]    active Im c_k
// -----------------------------------------------------------------------------
module dpd_coef_bank
    import dpd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       coef_wr_en_i,
    input  logic [3:0] coef_addr_i,
    input  coef_t      coef_wdata_i,
    input  logic       coef_commit_i,
    output coef_t      coef_re_o [NUM_TERMS],
    output coef_t      coef_im_o [NUM_TERMS]
);

    coef_t shadow_re_q [NUM_TERMS];
    coef_t shadow_im_q [NUM_TERMS];
    coef_t shadow_re_d [NUM_TERMS];
    coef_t shadow_im_d [NUM_TERMS];
    coef_t active_re_q [NUM_TERMS];
    coef_t active_im_q [NUM_TERMS];
    coef_t active_re_d [NUM_TERMS];
    coef_t active_im_d [NUM_TERMS];

    always_comb begin
        // NOTE: every output of this block is given a default first so no
        // path through the decode leaves a value unassigned (no latches).
        for (int k = 0; k < NUM_TERMS; k++) begin
            shadow_re_d[k] = shadow_re_q[k];
            shadow_im_d[k] = shadow_im_q[k];
            active_re_d[k] = active_re_q[k];
            active_im_d[k] = active_im_q[k];
        end
        // Commit copies the registered shadow values, i.e. the contents
        // before any write happening in the same cycle.
        if (coef_commit_i) begin
            for (int k = 0; k < NUM_TERMS; k++) begin
                active_re_d[k] = shadow_re_q[k];
                active_im_d[k] = shadow_im_q[k];
            end
        end
        if (coef_wr_en_i) begin
            for (int k = 0; k < NUM_TERMS; k++) begin
                if (coef_addr_i == ADDR_RE_BASE + 4'(k)) shadow_re_d[k] = coef_wdata_i;
                if (coef_addr_i == ADDR_IM_BASE + 4'(k)) shadow_im_d[k] = coef_wdata_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: these register arrays are reset element by element because
            // their reset value (identity) is functionally required; they are
            // flops, not a RAM, so this costs nothing special.
            for (int k = 0; k < NUM_TERMS; k++) begin
                shadow_re_q[k] <= (k == 0) ? COEF_UNITY : '0;
                shadow_im_q[k] <= '0;
                active_re_q[k] <= (k == 0) ? COEF_UNITY : '0;
                active_im_q[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            for (int k = 0; k < NUM_TERMS; k++) begin
                shadow_re_q[k] <= shadow_re_d[k];
                shadow_im_q[k] <= shadow_im_d[k];
                active_re_q[k] <= active_re_d[k];
                active_im_q[k] <= active_im_d[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_TERMS; k++) begin
            coef_re_o[k] = active_re_q[k];
            coef_im_o[k] = active_im_q[k];
        end
    end

endmodule

// File: rtl/dpd_poly_gain.sv
// -----------------------------------------------------------------------------
// dpd_poly_gain
// Memoryless DPD polynomial: g = sum_k c_k * |x|^k (complex c_k, real |x|^k),
// y = x * g, saturated to Q1.19. Four pipeline stages from mag_k to sig_out;
// the sample path has an extra X_DELAY-cycle delay line so x lines up with
// the magnitude-stage output that feeds mag_0..mag_4.
//
// Optional feature: define DPD_POLY_SAT_CNT_EN to build the output
// saturation event counter; otherwise sat_cnt is tied to 0.
//
// Parameters:
//   X_DELAY       magnitude-stage latency compensated on sig_in (default 4)
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   sig_in_i/q            Q1.19 signed input sample
//   in_valid              qualifies mag_0..mag_4
//   mag_0..mag_4          unsigned Q1.19 |x|^0..|x|^4
//   coef_wr_en/addr/wdata shadow coefficient write port
//   coef_commit           shadow -> active copy pulse
//   sig_out_i/q           Q1.19 saturated output y
//   out_valid             qualifies sig_out (in_valid delayed 4)
//   sat_cnt               saturating count of saturated valid outputs
// -----------------------------------------------------------------------------
module dpd_poly_gain
    import dpd_pkg::*;
#(
    parameter int X_DELAY = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [SAMPLE_W-1:0] sig_in_i,
    input  logic signed [SAMPLE_W-1:0] sig_in_q,
    input  logic                       in_valid,
    input  logic        [MAG_W-1:0]    mag_0,
    input  logic        [MAG_W-1:0]    mag_1,
    input  logic        [MAG_W-1:0]    mag_2,
    input  logic        [MAG_W-1:0]    mag_3,
    input  logic        [MAG_W-1:0]    mag_4,
    input  logic                       coef_wr_en,
    input  logic        [3:0]          coef_addr,
    input  logic signed [COEF_W-1:0]   coef_wdata,
    input  logic                       coef_commit,
    output logic signed [SAMPLE_W-1:0] sig_out_i,
    output logic signed [SAMPLE_W-1:0] sig_out_q,
    output logic                       out_valid,
    output logic        [15:0]         sat_cnt
);

    // x must reach stage 3 together with g, which is two stages past mag_k.
    localparam int XD_LEN = X_DELAY + 2;

    coef_t            coef_re [NUM_TERMS];
    coef_t            coef_im [NUM_TERMS];
    logic [MAG_W-1:0] mag     [NUM_TERMS];

    dpd_coef_bank u_coef_bank (
        .clk           (clk),
        .rst           (rst),
        .coef_wr_en_i  (coef_wr_en),
        .coef_addr_i   (coef_addr),
        .coef_wdata_i  (coef_wdata),
        .coef_commit_i (coef_commit),
        .coef_re_o     (coef_re),
        .coef_im_o     (coef_im)
    );

    assign mag[0] = mag_0;
    assign mag[1] = mag_1;
    assign mag[2] = mag_2;
    assign mag[3] = mag_3;
    assign mag[4] = mag_4;

    // Pipeline state.
    sample_t            xi_dly_q [XD_LEN];
    sample_t            xq_dly_q [XD_LEN];
    logic signed [40:0] p_re_q   [NUM_TERMS];
    logic signed [40:0] p_im_q   [NUM_TERMS];
    logic signed [40:0] p_re_d   [NUM_TERMS];
    logic signed [40:0] p_im_d   [NUM_TERMS];
    sample_t            g_i_q, g_q_q;
    logic signed [39:0] ii_q, qq_q, iq_q, qi_q;
    sample_t            out_i_q, out_q_q;
    logic [3:0]         vld_q;

    // Combinational stage results.
    logic signed [43:0] sum_re_d, sum_im_d;
    logic signed [40:0] yi_full_d, yq_full_d;
    rs_t                rs_gi, rs_gq, rs_yi, rs_yq;

    always_comb begin
        // Stage 1: mag_k is unsigned, so a zero sign bit is prepended
        // before the signed multiply.
        for (int k = 0; k < NUM_TERMS; k++) begin
            p_re_d[k] = 41'($signed({1'b0, mag[k]})) * 41'(coef_re[k]);
            p_im_d[k] = 41'($signed({1'b0, mag[k]})) * 41'(coef_im[k]);
        end

        // Stage 2: accumulate, then bring Q3.37 back to Q2.18.
        sum_re_d = '0;
        sum_im_d = '0;
        for (int k = 0; k < NUM_TERMS; k++) begin
            sum_re_d = sum_re_d + 44'(p_re_q[k]);
            sum_im_d = sum_im_d + 44'(p_im_q[k]);
        end
        rs_gi = round_sat(48'(sum_re_d), G_SHIFT);
        rs_gq = round_sat(48'(sum_im_d), G_SHIFT);

        // Stage 4: complex combine, Q3.37 back to Q1.19.
        yi_full_d = 41'(ii_q) - 41'(qq_q);
        yq_full_d = 41'(iq_q) + 41'(qi_q);
        rs_yi     = round_sat(48'(yi_full_d), Y_SHIFT);
        rs_yq     = round_sat(48'(yq_full_d), Y_SHIFT);
    end

    // g is clipped to the coefficient range; that event is not reported.
    logic g_sat_unused;
    assign g_sat_unused = rs_gi.sat | rs_gq.sat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < XD_LEN; s++) begin
                xi_dly_q[s] <= '0;
                xq_dly_q[s] <= '0;
            end
            for (int k = 0; k < NUM_TERMS; k++) begin
                p_re_q[k] <= '0;
                p_im_q[k] <= '0;
            end
            g_i_q   <= '0;
            g_q_q   <= '0;
            ii_q    <= '0;
            qq_q    <= '0;
            iq_q    <= '0;
            qi_q    <= '0;
            out_i_q <= '0;
            out_q_q <= '0;
            vld_q   <= '0;
        end else begin
            xi_dly_q[0] <= sig_in_i;
            xq_dly_q[0] <= sig_in_q;
            for (int s = 1; s < XD_LEN; s++) begin
                xi_dly_q[s] <= xi_dly_q[s-1];
                xq_dly_q[s] <= xq_dly_q[s-1];
            end
            for (int k = 0; k < NUM_TERMS; k++) begin
                p_re_q[k] <= p_re_d[k];
                p_im_q[k] <= p_im_d[k];
            end
            g_i_q   <= rs_gi.val;
            g_q_q   <= rs_gq.val;
            ii_q    <= 40'(xi_dly_q[XD_LEN-1]) * 40'(g_i_q);
            qq_q    <= 40'(xq_dly_q[XD_LEN-1]) * 40'(g_q_q);
            iq_q    <= 40'(xi_dly_q[XD_LEN-1]) * 40'(g_q_q);
            qi_q    <= 40'(xq_dly_q[XD_LEN-1]) * 40'(g_i_q);
            out_i_q <= rs_yi.val;
            out_q_q <= rs_yq.val;
            vld_q   <= {vld_q[2:0], in_valid};
        end
    end

    assign sig_out_i = out_i_q;
    assign sig_out_q = out_q_q;
    assign out_valid = vld_q[3];

`ifdef DPD_POLY_SAT_CNT_EN
    logic [15:0] sat_cnt_q;
    logic        sat_any;

    // vld_q[2] travels with the stage-3 products, so it marks the cycle in
    // which the sample being rounded here becomes a valid output.
    assign sat_any = rs_yi.sat | rs_yq.sat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_cnt_q <= '0;
        end else if (coef_commit) begin
            sat_cnt_q <= '0;
        end else if (vld_q[2] && sat_any && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_q <= sat_cnt_q + 16'd1;
        end
    end

    assign sat_cnt = sat_cnt_q;
`else
    logic y_sat_unused;
    assign y_sat_unused = rs_yi.sat | rs_yq.sat;
    assign sat_cnt      = '0;
`endif

endmodule

// File: tb/tb_dpd_poly_gain.sv
// -----------------------------------------------------------------------------
// tb_dpd_poly_gain
// Directed bench for dpd_poly_gain with hand-computed expected values.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_dpd_poly_gain;

    localparam int XD = 4;
    localparam int ONE_MAG = 524287;   // |x|^0 = 0x7FFFF
`ifdef DPD_POLY_SAT_CNT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic signed [19:0] sig_in_i, sig_in_q;
    logic               in_valid;
    logic        [19:0] mag_0, mag_1, mag_2, mag_3, mag_4;
    logic               coef_wr_en;
    logic        [3:0]  coef_addr;
    logic signed [19:0] coef_wdata;
    logic               coef_commit;
    logic signed [19:0] sig_out_i, sig_out_q;
    logic               out_valid;
    logic        [15:0] sat_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    dpd_poly_gain #(.X_DELAY(XD)) dut (
        .clk         (clk),
        .rst         (rst),
        .sig_in_i    (sig_in_i),
        .sig_in_q    (sig_in_q),
        .in_valid    (in_valid),
        .mag_0       (mag_0),
        .mag_1       (mag_1),
        .mag_2       (mag_2),
        .mag_3       (mag_3),
        .mag_4       (mag_4),
        .coef_wr_en  (coef_wr_en),
        .coef_addr   (coef_addr),
        .coef_wdata  (coef_wdata),
        .coef_commit (coef_commit),
        .sig_out_i   (sig_out_i),
        .sig_out_q   (sig_out_q),
        .out_valid   (out_valid),
        .sat_cnt     (sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_coef(input logic [3:0] addr, input int data);
        coef_wr_en = 1'b1;
        coef_addr  = addr;
        coef_wdata = 20'(data);
        tick(1);
        coef_wr_en = 1'b0;
    endtask

    task automatic commit();
        coef_commit = 1'b1;
        tick(1);
        coef_commit = 1'b0;
    endtask

    task automatic set_in(input int xi, input int xq, input int m0, input int m2);
        sig_in_i = 20'(xi);
        sig_in_q = 20'(xq);
        mag_0    = 20'(m0);
        mag_1    = 20'd0;
        mag_2    = 20'(m2);
        mag_3    = 20'd0;
        mag_4    = 20'd0;
    endtask

    // Hold a constant input long enough to fill the whole pipeline.
    task automatic apply(input string tag, input int xi, input int xq, input int m0,
                         input int m2, input int exp_i, input int exp_q);
        set_in(xi, xq, m0, m2);
        in_valid = 1'b1;
        tick(XD + 6);
        check({tag, "_i"}, sig_out_i, exp_i);
        check({tag, "_q"}, sig_out_q, exp_q);
        in_valid = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        coef_wr_en  = 1'b0;
        coef_addr   = 4'd0;
        coef_wdata  = 20'sd0;
        coef_commit = 1'b0;
        set_in(0, 0, 0, 0);
        tick(2);
        check("rst_out_i", sig_out_i, 0);
        check("rst_out_q", sig_out_q, 0);
        check("rst_valid", out_valid, 0);
        check("rst_satcnt", sat_cnt, 0);
        rst = 1'b0;

        // Reset identity, with exact latency on both the x and mag paths.
        set_in(0, 0, ONE_MAG, 12345);
        mag_1 = 20'd777;
        tick(2);
        sig_in_i = 20'sd262144;
        sig_in_q = -20'sd131072;
        tick(1);
        sig_in_i = 20'sd0;
        sig_in_q = 20'sd0;
        tick(XD - 1);
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        tick(2);
        check("id_early_valid", out_valid, 0);
        check("id_early_i", sig_out_i, 0);
        tick(1);
        check("id_valid", out_valid, 1);
        check("id_i", sig_out_i, 262144);
        check("id_q", sig_out_q, -131072);
        tick(1);
        check("id_valid_drop", out_valid, 0);

        // Linear gain 0.5.
        write_coef(4'd0, 131072);
        commit();
        apply("lin", 400000, 0, ONE_MAG, 0, 200000, 0);

        // Cubic term: g = 1 - 0.1*0.5 = 249037 in Q2.18.
        write_coef(4'd0, 262144);
        write_coef(4'd2, -26214);
        commit();
        apply("cubic", 300000, 0, ONE_MAG, 262144, 285000, 0);

        // Pure imaginary gain j; writes to unmapped addresses are dropped.
        write_coef(4'd2, 0);
        write_coef(4'd0, 0);
        write_coef(4'd8, 262144);
        write_coef(4'd5, 99999);
        write_coef(4'd13, 99999);
        commit();
        apply("imag", 100000, 50000, ONE_MAG, ONE_MAG, -50000, 100000);

        // Saturation: g ~ 2.0, both rails clip; only valid outputs count.
        write_coef(4'd8, 0);
        write_coef(4'd0, 524287);
        commit();
        check("sat_cnt_clear0", sat_cnt, 0);
        set_in(500000, 500000, ONE_MAG, 0);
        tick(XD + 6);
        check("sat_no_valid_cnt", sat_cnt, 0);
        in_valid = 1'b1;
        tick(3);
        in_valid = 1'b0;
        tick(1);
        check("sat_valid", out_valid, 1);
        check("sat_i", sig_out_i, 524287);
        check("sat_q", sig_out_q, 524287);
        tick(4);
        check("sat_valid_drop", out_valid, 0);
        check("sat_cnt", sat_cnt, SAT_EN ? 3 : 0);
        set_in(-500000, 0, ONE_MAG, 0);
        apply("sat_neg", -500000, 0, ONE_MAG, 0, -524288, 0);

        // Commit clears the counter.
        write_coef(4'd0, 262144);
        commit();
        check("sat_cnt_commit_clr", sat_cnt, 0);

        // Write and commit in the same cycle: commit takes old shadow.
        coef_wr_en  = 1'b1;
        coef_addr   = 4'd0;
        coef_wdata  = 20'sd0;
        coef_commit = 1'b1;
        tick(1);
        coef_wr_en  = 1'b0;
        coef_commit = 1'b0;
        apply("race_id", 123456, -7890, ONE_MAG, 0, 123456, -7890);
        commit();
        apply("race_zero", 123456, -7890, ONE_MAG, 0, 0, 0);

        // Reset in the middle of continuous traffic.
        write_coef(4'd0, 262144);
        commit();
        set_in(100000, 50000, ONE_MAG, 0);
        in_valid = 1'b1;
        tick(XD + 6);
        check("stream_i", sig_out_i, 100000);
        check("stream_valid", out_valid, 1);
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        check("midrst_i", sig_out_i, 0);
        check("midrst_q", sig_out_q, 0);
        check("midrst_valid", out_valid, 0);
        tick(2);
        rst = 1'b0;
        tick(2);
        in_valid = 1'b1;
        tick(3);
        check("post_rst_valid_early", out_valid, 0);
        tick(1);
        check("post_rst_valid", out_valid, 1);
        check("post_rst_flush_i", sig_out_i, 0);
        tick(XD + 4);
        check("post_rst_stream_i", sig_out_i, 100000);
        check("post_rst_stream_q", sig_out_q, 50000);
        in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
